// File: rtl/vec_alu_seq_if.sv
// vec_alu_seq_if: op handshake, downstream ALU and result port bundle.
// slave = vec_alu_seq side, master = producer/consumer/ALU side.
interface vec_alu_seq_if #(
  parameter int VLEN = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_ctl;
  logic [3:0]      in_len;
  logic [VLEN*8-1:0] in_a;
  logic [VLEN*8-1:0] in_b;
  logic            in_bcast;
  logic [3:0]      alu_ctl;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [7:0]      alu_out;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN*8-1:0] out_data;
  logic [3:0]      out_len;

  modport slave (
    input  in_valid, in_ctl, in_len,
    input  in_a, in_b, in_bcast,
    input  alu_out, out_ready,
    output in_ready, alu_ctl,
    output alu_a, alu_b,
    output out_valid, out_data, out_len
  );

  modport master (
    output in_valid, in_ctl, in_len,
    output in_a, in_b, in_bcast,
    output alu_out, out_ready,
    input  in_ready, alu_ctl,
    input  alu_a, alu_b,
    input  out_valid, out_data, out_len
  );
endinterface

// File: rtl/vec_alu_seq.sv
// vec_alu_seq: streams a vector op one element per cycle through an external ALU.
// Optional macro SCALAR_BCAST_EN: captured bcast makes b[0] the operand for all elements.
module vec_alu_seq #(
  parameter int VLEN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  vec_alu_seq_if.slave  bus
);
  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int DW = VLEN * 8;
  localparam logic [3:0] VMAX = 4'(VLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            bcast_q, bcast_d;
  logic [DW-1:0]   res_q, res_d;
  logic [3:0]      len_clamp;

  // State and op registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bcast_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bcast_q <= bcast_d;
      res_q   <= res_d;
    end
  end

  // Next state: capture in IDLE, one element per RUN cycle, hold in DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    ctl_d     = ctl_q;
    a_d       = a_q;
    b_d       = b_q;
    bcast_d   = bcast_q;
    res_d     = res_q;
    len_clamp = (bus.in_len > VMAX) ? VMAX : bus.in_len;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          len_d   = len_clamp;
          ctl_d   = bus.in_ctl;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          bcast_d = bus.in_bcast;
          res_d   = '0;
          idx_d   = '0;
          state_d = (len_clamp == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        res_d[idx_q*8 +: 8] = bus.alu_out;
        if (4'(idx_q) == len_q - 4'd1) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ALU operands only in RUN, result only in DONE.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = '0;
    bus.out_len   = '0;
    bus.alu_ctl   = '0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    if (state_q == DONE) begin
      bus.out_data = res_q;
      bus.out_len  = len_q;
    end
    if (state_q == RUN) begin
      bus.alu_ctl = ctl_q;
      bus.alu_a   = a_q[idx_q*8 +: 8];
`ifdef SCALAR_BCAST_EN
      bus.alu_b   = bcast_q ? b_q[7:0] : b_q[idx_q*8 +: 8];
`else
      bus.alu_b   = b_q[idx_q*8 +: 8];
`endif
    end
  end

`ifndef SCALAR_BCAST_EN
  logic unused_bcast;
  assign unused_bcast = bcast_q;
`endif

endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: directed vector table plus reset/backpressure sequences.
// Models the downstream ALU: 0 add, 1 sub, 2 xor, 3 and.
module tb_vec_alu_seq;
  localparam int VLEN = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vec_alu_seq_if #(.VLEN(VLEN)) bus ();

  vec_alu_seq #(.VLEN(VLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_out = 8'h00;
    case (bus.alu_ctl)
      4'd0: bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_out = bus.alu_a - bus.alu_b;
      4'd2: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'd3: bus.alu_out = bus.alu_a & bus.alu_b;
      default: bus.alu_out = 8'h00;
    endcase
  end

  typedef struct {
    logic [3:0]  ctl;
    logic [3:0]  len;
    logic [63:0] a;
    logic [63:0] b;
    logic        bcast;
    logic [63:0] exp_data;
    logic [3:0]  exp_len;
    int          exp_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, output int lat,
                        output logic [63:0] d, output logic [3:0] l);
    bus.in_ctl   = v.ctl;
    bus.in_len   = v.len;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_bcast = v.bcast;
    bus.in_valid = 1'b1;
    check("in_ready_pre", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = {$urandom, $urandom};
    bus.in_b     = {$urandom, $urandom};
    bus.in_ctl   = 4'hF;
    bus.in_len   = 4'hF;
    bus.in_bcast = ~v.bcast;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = bus.out_data;
    l = bus.out_len;
  endtask

  task automatic release_op();
    check("done_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_alu_a", 64'(bus.alu_a), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] d;
    logic [3:0]  l;
    logic [63:0] held;
    checks = 0;
    errors = 0;

    tbl[0] = '{4'd0, 4'd4, 64'h04030201, 64'h10101010, 1'b0,
               64'h14131211, 4'd4, 5};
    tbl[1] = '{4'd1, 4'd1, 64'h1122334455667700, 64'h0101010101010101,
               1'b0, 64'h00000000000000FF, 4'd1, 2};
    tbl[2] = '{4'd0, 4'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0,
               64'h0, 4'd0, 1};
    tbl[3] = '{4'd0, 4'd12, 64'h0807060504030201, 64'h1010101010101010,
               1'b0, 64'h1817161514131211, 4'd8, 9};
    tbl[4] = '{4'd2, 4'd2, 64'hF00F, 64'h55AA, 1'b0,
               64'hA5A5, 4'd2, 3};
`ifdef SCALAR_BCAST_EN
    tbl[5] = '{4'd2, 4'd2, 64'hF00F, 64'h55AA, 1'b1,
               64'h5AA5, 4'd2, 3};
`else
    tbl[5] = '{4'd2, 4'd2, 64'hF00F, 64'h55AA, 1'b1,
               64'hA5A5, 4'd2, 3};
`endif
    tbl[6] = '{4'd0, 4'd3, 64'hFF00FF80, 64'h01010180, 1'b0,
               64'h00010000, 4'd3, 4};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ctl    = '0;
    bus.in_len    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_bcast  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_len", 64'(bus.out_len), 64'd0);
    check("rst_alu_b", 64'(bus.alu_b), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i], lat, d, l);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("v%0d_data", i), d, tbl[i].exp_data);
      check($sformatf("v%0d_len", i), 64'(l), 64'(tbl[i].exp_len));
      release_op();
    end

    run_op(tbl[0], lat, d, l);
    held = d;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", bus.out_data, held);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_rel_valid", 64'(bus.out_valid), 64'd0);
    check("bp_rel_ready", 64'(bus.in_ready), 64'd1);

    bus.in_ctl   = 4'd3;
    bus.in_len   = 4'd6;
    bus.in_a     = 64'h0000_F0E0_D0C0_B0A0;
    bus.in_b     = 64'h0000_FFFF_FFFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("run_alu_ctl", 64'(bus.alu_ctl), 64'd3);
    check("run_alu_a0", 64'(bus.alu_a), 64'hA0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("run_alu_a2", 64'(bus.alu_a), 64'hC0);
    rst_n = 1'b0;
    #1;
    check("mid_alu_a", 64'(bus.alu_a), 64'd0);
    check("mid_alu_b", 64'(bus.alu_b), 64'd0);
    check("mid_alu_ctl", 64'(bus.alu_ctl), 64'd0);
    check("mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_out_data", bus.out_data, 64'd0);
    check("mid_out_len", 64'(bus.out_len), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_held_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_op(tbl[0], lat, d, l);
    check("post_latency", 64'(lat), 64'(tbl[0].exp_lat));
    check("post_data", d, tbl[0].exp_data);
    check("post_len", 64'(l), 64'(tbl[0].exp_len));
    release_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 The block SHALL have parameter VLEN, default 8: maximum elements per vector, each 8 bits wide.
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  in  1  vector op offered.
REQ-005 The block SHALL have port in_ready  out  1  op accepted when in_valid && in_ready.
REQ-006 The block SHALL have port in_ctl  in  4  ALU opcode, passed unchanged to alu_ctl.
REQ-007 The block SHALL have port in_len  in  4  element count, 0..VLEN; values above VLEN are clamped to VLEN.
REQ-008 The block SHALL have ports in_a and in_b  in  VLEN*8  packed operand vectors; element i is at bits [8i+7:8i].
REQ-009 The block SHALL have port in_bcast  in  1  scalar-broadcast request (see REQ-030).
REQ-010 The block SHALL have ports alu_ctl (out 4), alu_a (out 8) and alu_b (out 8), driving the downstream 8-bit ALU.
REQ-011 The block SHALL have port alu_out  in  8  combinational ALU result for the current alu_a/alu_b.
REQ-012 The block SHALL have port out_valid  out  1  result vector available.
REQ-013 The block SHALL have port out_ready  in  1  consumer accepts the result.
REQ-014 The block SHALL have ports out_data (out VLEN*8) and out_len (out 4): packed result vector and its element count.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, on in_valid: the block SHALL capture ctl, clamped len, a, b and bcast; clear the result register and element counter idx; and go to RUN, or to DONE if len==0.
REQ-017 In RUN, the block SHALL drive alu_a = a[idx] and alu_b = b[idx] (or the broadcast operand), with alu_ctl = captured ctl.
REQ-018 Each RUN cycle SHALL latch alu_out into result element idx and increment idx.
REQ-019 When idx == len-1, the block SHALL latch the final element and go to DONE.
REQ-020 One element SHALL be processed per cycle; out_valid SHALL rise exactly len+1 clock edges after the accepting edge (1 edge when len==0).
REQ-021 In DONE, out_valid SHALL be 1, and out_data and out_len SHALL be held stable until out_ready.
REQ-022 On out_ready in DONE, the block SHALL return to IDLE; a new op SHALL be accepted no earlier than the following cycle (no same-cycle bypass).
REQ-023 Result elements at index >= len SHALL read 0.
REQ-024 Outside RUN, alu_a, alu_b and alu_ctl SHALL be 0.
REQ-025 in_* changes after acceptance SHALL NOT affect the op in flight.
REQ-026 idx SHALL be wide enough for VLEN-1 and SHALL never wrap within an op.

Reset
REQ-027 While rst_n == 0, the block SHALL immediately force state IDLE, idx=0, in_ready=1 (after release), out_valid=0, out_data=0, out_len=0, and alu_* outputs = 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the op with no result delivered.
REQ-029 The block SHALL be ready to accept an op on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With SCALAR_BCAST_EN defined: when the captured bcast==1, alu_b SHALL be b[0] for every element.
REQ-031 Without SCALAR_BCAST_EN: in_bcast SHALL be ignored and alu_b SHALL always be b[idx]; the port SHALL remain present.

Verification
REQ-032 Add: len=4, ctl=0, a={04,03,02,01}, b={10,10,10,10} -> out_valid on the 5th edge after accept; out_data low 32 bits=14131211, rest 0; out_len=4.
REQ-033 Sub wrap: len=1, ctl=1, a[0]=00, b[0]=01 -> out_data[7:0]=FF; out_valid 2 edges after accept.
REQ-034 Backpressure: complete an op with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; accepted on the out_ready edge, then in_ready=1 next cycle.
REQ-035 len=0 and len=12 (VLEN=8) -> len=0: out_valid after 1 edge, out_data=0, out_len=0; len=12: 8 RUN cycles, out_len=8.
REQ-036 Reset mid-RUN: assert rst_n=0 at idx=2 of a len=6 op -> all outputs 0 immediately, no out_valid; next op completes correctly.
REQ-037 Broadcast: bcast=1, ctl=2, a={0F,F0}, b={AA,55} -> with SCALAR_BCAST_EN, out={A5,5A}; without it, out={A5,A5}.
